// File: rtl/gps_sim_pkg.sv
// Purpose: shared defaults and state type for the GPS sample ROM streamer.
// Contents: default ROM geometry and word width, stream FSM state encoding.
package gps_sim_pkg;

    localparam int unsigned DEF_ADDR_W      = 22;
    localparam int unsigned DEF_NUM_SAMPLES = 4000000;
    localparam int unsigned DEF_WORD_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stream_state_t;

endpackage

// File: rtl/sample_bit_packer.sv
// Purpose: packs a stream of 1-bit samples into WORD_W-bit words behind a
//          valid/ready output register; flushes a zero-padded partial word.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   i_bit            sample bit (ROM data_out)
//   i_bit_valid      i_bit lands this cycle
//   i_bit_final      the landing bit is the last of the run
//   i_flush          no more bits will arrive; emit any partial word
//   o_bit_cnt        bits currently held in the pack register
//   o_word_data      packed word
//   o_word_valid     o_word_data valid
//   i_word_ready     downstream accepts
//   o_word_last      final word of the run
module sample_bit_packer #(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned CNT_W     = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bit,
    input  logic              i_bit_valid,
    input  logic              i_bit_final,
    input  logic              i_flush,
    output logic [CNT_W-1:0]  o_bit_cnt,
    output logic [WORD_W-1:0] o_word_data,
    output logic              o_word_valid,
    input  logic              i_word_ready,
    output logic              o_word_last
);

    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0] r_word_data;
    logic              r_word_valid;
    logic              r_word_last;

    logic [CNT_W-1:0]  w_pos;
    logic [WORD_W-1:0] w_filled;
    logic              w_out_free;

    // Unfilled positions stay zero, so a partial word is already padded.
    always_comb begin
        w_pos    = (MSB_FIRST != 0) ? (CNT_W'(WORD_W - 1) - r_bit_cnt) : r_bit_cnt;
        w_filled = r_shift;
        w_filled[w_pos] = i_bit;
    end

    assign w_out_free = !r_word_valid || i_word_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_word_last  <= 1'b0;
        end else begin
            if (r_word_valid && i_word_ready) begin
                r_word_valid <= 1'b0;
            end
            if (i_bit_valid) begin
                if (r_bit_cnt == CNT_W'(WORD_W - 1)) begin
                    // Output register is free here: upstream stalls the fetch otherwise.
                    r_word_data  <= w_filled;
                    r_word_valid <= 1'b1;
                    r_word_last  <= i_bit_final;
                    r_shift      <= '0;
                    r_bit_cnt    <= '0;
                end else begin
                    r_shift   <= w_filled;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end else if (i_flush && (r_bit_cnt != '0) && w_out_free) begin
                r_word_data  <= r_shift;
                r_word_valid <= 1'b1;
                r_word_last  <= 1'b1;
                r_shift      <= '0;
                r_bit_cnt    <= '0;
            end
        end
    end

    assign o_bit_cnt    = r_bit_cnt;
    assign o_word_data  = r_word_data;
    assign o_word_valid = r_word_valid;
    assign o_word_last  = r_word_last;

endmodule

// File: rtl/gps_sample_streamer.sv
// Purpose: walks the 1-bit GPS IF sample ROM and streams packed words with
//          one-shot / looped playback, stop-with-flush and lossless backpressure.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, stop       begin playback (IDLE only) / halt and flush
//   loop_en           wrap to address 0 after the last sample
//   rom_addr/rom_data ROM address out, registered 1-cycle data in
//   word_data/valid/ready/last  packed output stream
//   busy              not IDLE
//   wrap_pulse        one cycle after a looped fetch wraps to 0
module gps_sample_streamer
    import gps_sim_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int unsigned WORD_W      = DEF_WORD_W,
    parameter int unsigned MSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic              busy,
    output logic              wrap_pulse
);

    localparam int unsigned CNT_W = $clog2(WORD_W);
    localparam int unsigned SUM_W = CNT_W + 1;

    stream_state_t     r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_pending;
    logic              r_wrap_pulse;

    logic [CNT_W-1:0]  w_bit_cnt;
    logic [SUM_W-1:0]  w_fill;
    logic              w_stall;
    logic              w_fetch_en;
    logic              w_bit_final;
    logic              w_flush;
    logic              w_drain_done;

    // Bits already held plus the one in flight; one short of a word means the
    // next fetch would complete it, which needs a free output register.
    assign w_fill       = SUM_W'(w_bit_cnt) + SUM_W'(r_rd_pending);
    assign w_stall      = (w_fill == SUM_W'(WORD_W - 1)) && word_valid && !word_ready;
    assign w_fetch_en   = (r_state == RUN) && !stop && !w_stall;
    // The landing bit is final when no further fetch can follow it.
    assign w_bit_final  = r_rd_pending && ((r_state == DRAIN) || ((r_state == RUN) && stop));
    assign w_flush      = (r_state == DRAIN) && !r_rd_pending;
    assign w_drain_done = w_flush && (w_bit_cnt == '0) && (!word_valid || word_ready);

    // Playback FSM, address counter and read-pending tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_rd_pending <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_rd_pending <= w_fetch_en;
            r_wrap_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        r_state <= RUN;
                        r_addr  <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= DRAIN;
                    end else if (w_fetch_en) begin
                        if (r_addr == ADDR_W'(NUM_SAMPLES - 1)) begin
                            if (loop_en) begin
                                r_addr       <= '0;
                                r_wrap_pulse <= 1'b1;
                            end else begin
                                r_state <= DRAIN;
                            end
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sample_bit_packer #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bit        (rom_data),
        .i_bit_valid  (r_rd_pending),
        .i_bit_final  (w_bit_final),
        .i_flush      (w_flush),
        .o_bit_cnt    (w_bit_cnt),
        .o_word_data  (word_data),
        .o_word_valid (word_valid),
        .i_word_ready (word_ready),
        .o_word_last  (word_last)
    );

    assign rom_addr   = r_addr;
    assign busy       = (r_state != IDLE);
    assign wrap_pulse = r_wrap_pulse;

endmodule
